rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x32 register file between two
//  writeback requesters: req0 (ALU path) and req1 (load/multi-cycle path).
//  Uses valid/ready handshakes and round-robin arbitration, with a registered write port.
//  Keeps a per-register busy scoreboard so issue logic can stall on operands with pending writes.
//  Sits between the execute/memory stages and reg_file's waddr/wen/wdata.
// PARAMETERS
//  DATA_WIDTH  32  register data width
//  ADDR_WIDTH  5   register address width; 2**ADDR_WIDTH registers
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst         in   1      synchronous reset, active-low
//  req0_valid  in   1      requester 0 has a writeback
//  req0_addr   in   AW     requester 0 destination register
//  req0_data   in   DW     requester 0 write data
//  req0_ready  out  1      requester 0 granted this cycle
//  req1_valid  in   1      requester 1 has a writeback
//  req1_addr   in   AW     requester 1 destination register
//  req1_data   in   DW     requester 1 write data
//  req1_ready  out  1      requester 1 granted this cycle
//  rf_wen      out  1      to reg_file wen (registered)
//  rf_waddr    out  AW     to reg_file waddr (registered)
//  rf_wdata    out  DW     to reg_file wdata (registered)
//  rsv_valid   in   1      issue stage reserves a destination register
//  rsv_addr    in   AW     register to mark busy
//  chk_addr1   in   AW     operand 1 register to check
//  chk_addr2   in   AW     operand 2 register to check
//  chk_busy1   out  1      operand 1 has a pending write (combinational)
//  chk_busy2   out  1      operand 2 has a pending write (combinational)
//  fwd_hit1    out  1      operand 1 forwarded (RF_WB_FWD_EN only, else 0)
//  fwd_hit2    out  1      operand 2 forwarded (RF_WB_FWD_EN only, else 0)
//  fwd_data1   out  DW     forwarded operand 1 data (else 0)
//  fwd_data2   out  DW     forwarded operand 2 data (else 0)
// BEHAVIOUR
//  - Reset (rst=0 at posedge):
//      rf_wen=0, rf_waddr=0, rf_wdata=0.
//      All busy bits are 0; priority pointer selects req0.
//      req0_ready and req1_ready are 0 while rst=0.
//      Any in-flight transfer is dropped.
//  - Arbitration:
//      readyN is combinational from the valids and the pointer; at most one ready is high.
//      A single valid requester is granted in the same cycle.
//      If both are valid, the pointer's requester is granted.
//      After any grant, the pointer moves to the other requester.
//      The pointer is unchanged when no transfer occurs.
//  - Transfer = validN && readyN. The edge ending the transfer cycle registers
//    rf_wen=1, rf_waddr, rf_wdata. rf_wen lasts exactly one cycle per transfer;
//    reg_file latches the data on the following edge (handshake-to-RF = 2 edges).
//  - Back-to-back transfers are allowed every cycle; there is no bubble.
//  - An addr 0 transfer is accepted (ready=1), but rf_wen stays 0 and the scoreboard is unaffected.
//  - Scoreboard busy[r]:
//      Set at the edge with rsv_valid=1 and rsv_addr=r (r!=0).
//      Cleared at the edge with rf_wen=1 and rf_waddr=r.
//      If set and clear hit the same r on the same edge, the set wins.
//      busy[0] is constantly 0.
//      Reserving an already-busy register is legal; the bit stays 1.
//  - chk_busyN = busy[chk_addrN]. chk_addrN=0 gives 0.
// CONFIGURATION
//  - RF_WB_FWD_EN defined: when rf_wen=1 and rf_waddr==chk_addrN!=0:
//      fwd_hitN=1 and fwd_dataN=rf_wdata.
//      chk_busyN=0 for that cycle (forwarding masks the busy bit).
//      Otherwise fwd_hitN=0 and fwd_dataN=0.
//  - RF_WB_FWD_EN undefined: fwd_hitN and fwd_dataN are tied to 0; chk_busyN = busy bit only.
// TESTING
//  - Reset: hold rst=0 for 2 cycles with both valids high
//      -> readies 0, rf_wen 0, chk_busy 0 for all addresses.
//  - Contention: both valid every cycle, req0 addr 3 data 0xAA, req1 addr 4 data 0xBB
//      -> grants alternate req0, req1, req0...; rf_waddr sequence 3, 4, 3; rf_wen high every cycle.
//  - Scoreboard: rsv addr 7, then 3 idle cycles -> chk_busy1(7)=1 throughout;
//      req1 writes addr 7 -> chk_busy1 falls one cycle after rf_wen.
//  - Set/clear collision: rsv addr 5 on the same edge as rf_wen addr 5 -> busy[5] remains 1.
//  - Zero register: req0 addr 0 data 0xFF -> req0_ready=1, rf_wen stays 0; rsv addr 0 -> chk_busy 0.
//  - FWD (macro on): rf_wen=1 with addr 9 data 0x1234, chk_addr2=9
//      -> fwd_hit2=1, fwd_data2=0x1234, chk_busy2=0. Macro off -> fwd_hit2=0, chk_busy2=1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose
//   Shares the single write port of the register file between two writeback
//   requesters (req0 = ALU path, req1 = load/multi-cycle path) using
//   round-robin arbitration and a registered write port. A per-register busy
//   scoreboard lets the issue stage stall on operands with pending writes.
//
// Optional feature
//   RF_WB_FWD_EN : when defined, the registered write port is forwarded to the
//                  two operand check ports and masks their busy indication.
//                  When undefined, fwd_hit*/fwd_data* are tied to 0.
//
// Ports
//   clk, rst                 clock (posedge) and synchronous active-low reset
//   req0_valid/addr/data     requester 0 writeback request
//   req0_ready               requester 0 granted this cycle (combinational)
//   req1_valid/addr/data     requester 1 writeback request
//   req1_ready               requester 1 granted this cycle (combinational)
//   rf_wen/rf_waddr/rf_wdata registered write port to the register file
//   rsv_valid/rsv_addr       issue stage marks a destination register busy
//   chk_addr1/chk_addr2      operand registers to check
//   chk_busy1/chk_busy2      operand has a pending write (combinational)
//   fwd_hit1/fwd_hit2        operand served from the write port this cycle
//   fwd_data1/fwd_data2      forwarded operand data (0 when no hit)
//
// Handshake: a transfer happens in any cycle where reqN_valid && reqN_ready.
// ready is a pure function of both valids, the priority pointer and rst; a
// requester must hold valid/addr/data stable until it sees ready.
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic                  rsv_valid,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   input  logic [ADDR_WIDTH-1:0] chk_addr1,
   input  logic [ADDR_WIDTH-1:0] chk_addr2,
   output logic                  chk_busy1,
   output logic                  chk_busy2,
   output logic                  fwd_hit1,
   output logic                  fwd_hit2,
   output logic [DATA_WIDTH-1:0] fwd_data1,
   output logic [DATA_WIDTH-1:0] fwd_data2
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   // Priority pointer: 0 favours req0, 1 favours req1 when both are valid.
   logic ptr;

   // Per-register pending-write bits; bit 0 is never set.
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // Selected request for this cycle.
   logic                  xfer;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   // ---------------------------------------------------------------------------
   // Arbitration: a lone valid requester always wins; on contention the
   // pointer decides. Both readies are held low during reset.
   // ---------------------------------------------------------------------------
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (rst) begin
         req0_ready = req0_valid && (!req1_valid || (ptr == 1'b0));
         req1_ready = req1_valid && (!req0_valid || (ptr == 1'b1));
      end
   end

   always_comb begin
      xfer     = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      if (req0_valid && req0_ready) begin
         xfer     = 1'b1;
         sel_addr = req0_addr;
         sel_data = req0_data;
      end else if (req1_valid && req1_ready) begin
         xfer     = 1'b1;
         sel_addr = req1_addr;
         sel_data = req1_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Pointer and registered write port. A granted request to register 0 is
   // consumed (and still rotates the pointer) but never raises rf_wen.
   // rf_waddr/rf_wdata hold their last written values while rf_wen is low.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr      <= 1'b0;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= 1'b0;
         if (xfer) begin
            ptr <= req0_ready ? 1'b1 : 1'b0;
            if (sel_addr != '0) begin
               rf_wen   <= 1'b1;
               rf_waddr <= sel_addr;
               rf_wdata <= sel_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard. The clear from the write port is applied first so that a
   // reservation of the same register on the same edge overrides it.
   // ---------------------------------------------------------------------------
   always_comb begin
      busy_nxt = busy;
      if (rf_wen) begin
         busy_nxt[rf_waddr] = 1'b0;
      end
      if (rsv_valid) begin
         busy_nxt[rsv_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Operand check and optional forwarding from the registered write port.
   // A forward hit means the value is on its way into the register file this
   // cycle, so the operand need not stall even though its busy bit is still 1.
   // ---------------------------------------------------------------------------
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
`ifdef RF_WB_FWD_EN
      if (rf_wen && (rf_waddr == chk_addr1) && (chk_addr1 != '0)) begin
         fwd_hit1  = 1'b1;
         fwd_data1 = rf_wdata;
      end
      if (rf_wen && (rf_waddr == chk_addr2) && (chk_addr2 != '0)) begin
         fwd_hit2  = 1'b1;
         fwd_data2 = rf_wdata;
      end
`else
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
`endif
      chk_busy1 = busy[chk_addr1] && !fwd_hit1;
      chk_busy2 = busy[chk_addr2] && !fwd_hit2;
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr, chk_addr1, chk_addr2;
  logic          chk_busy1, chk_busy2, fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle just after it; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input int idx, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (idx == 0) begin
      req0_valid = v; req0_addr = a; req0_data = d;
    end else begin
      req1_valid = v; req1_addr = a; req1_data = d;
    end
  endtask

  task automatic drive_rsv(input logic v, input logic [AW-1:0] a);
    rsv_valid = v;
    rsv_addr  = a;
  endtask

  logic [AW-1:0] a_tmp;

  initial begin
    drive_req(0, 1'b1, 5'd3, 32'hAA);
    drive_req(1, 1'b1, 5'd4, 32'hBB);
    drive_rsv(1'b0, '0);
    chk_addr1 = '0;
    chk_addr2 = '0;
    rst = 1'b0;

    // ---- reset held for two edges with both valids high ----
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_wen", rf_wen, 0);
    end
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    for (int a = 0; a < 32; a++) begin
      chk_addr1 = a[AW-1:0];
      chk_addr2 = a[AW-1:0];
      settle();
      check("rst_busy1", chk_busy1, 0);
      check("rst_busy2", chk_busy2, 0);
    end

    // ---- contention: grants alternate req0, req1, req0 ----
    rst = 1'b1;
    settle();
    for (int c = 0; c < 3; c++) begin
      check("cont_ready0", req0_ready, (c % 2 == 0) ? 1 : 0);
      check("cont_ready1", req1_ready, (c % 2 == 0) ? 0 : 1);
      exp_q.push_back((c % 2 == 0) ? 5'd3 : 5'd4);
      tick();
      check("cont_wen", rf_wen, 1);
      a_tmp = exp_q.pop_front();
      check("cont_waddr", rf_waddr, a_tmp);
      check("cont_wdata", rf_wdata, (a_tmp == 5'd3) ? 32'hAA : 32'hBB);
    end
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    tick();
    check("idle_wen", rf_wen, 0);

    // ---- scoreboard: reserve 7, hold, then req1 writes 7 ----
    drive_rsv(1'b1, 5'd7);
    chk_addr1 = 5'd7;
    tick();
    drive_rsv(1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      settle();
      check("sb_busy7_idle", chk_busy1, 1);
      tick();
    end
    drive_req(1, 1'b1, 5'd7, 32'h77);
    settle();
    check("sb_ready1", req1_ready, 1);
    tick();
    drive_req(1, 1'b0, '0, '0);
    settle();
    check("sb_wen", rf_wen, 1);
    check("sb_waddr", rf_waddr, 7);
    check("sb_busy7_wen", chk_busy1, FWD ? 0 : 1);
    check("sb_fwd1", fwd_hit1, FWD ? 1 : 0);
    tick();
    check("sb_busy7_clr", chk_busy1, 0);

    // ---- set/clear collision on register 5 ----
    drive_req(0, 1'b1, 5'd5, 32'h55);
    settle();
    check("col_ready0", req0_ready, 1);
    tick();
    drive_req(0, 1'b0, '0, '0);
    drive_rsv(1'b1, 5'd5);
    chk_addr1 = 5'd5;
    settle();
    check("col_wen", rf_wen, 1);
    check("col_waddr", rf_waddr, 5);
    tick();
    drive_rsv(1'b0, '0);
    settle();
    check("col_busy5", chk_busy1, 1);
    tick();
    check("col_busy5_hold", chk_busy1, 1);

    // ---- zero register: accepted, no write, no reservation ----
    drive_req(0, 1'b1, 5'd0, 32'hFF);
    drive_rsv(1'b1, 5'd0);
    chk_addr2 = 5'd0;
    settle();
    check("z_ready0", req0_ready, 1);
    tick();
    drive_req(0, 1'b0, '0, '0);
    drive_rsv(1'b0, '0);
    settle();
    check("z_wen", rf_wen, 0);
    check("z_busy0", chk_busy2, 0);
    // pointer advanced past req0 by the addr-0 grant
    drive_req(0, 1'b1, 5'd3, 32'hAA);
    drive_req(1, 1'b1, 5'd4, 32'hBB);
    settle();
    check("z_ptr_ready0", req0_ready, 0);
    check("z_ptr_ready1", req1_ready, 1);
    tick();
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    check("z_ptr_waddr", rf_waddr, 4);

    // ---- forwarding on register 9 ----
    drive_rsv(1'b1, 5'd9);
    tick();
    drive_rsv(1'b0, '0);
    chk_addr2 = 5'd9;
    settle();
    check("fw_busy_pre", chk_busy2, 1);
    check("fw_hit_pre", fwd_hit2, 0);
    drive_req(0, 1'b1, 5'd9, 32'h1234);
    tick();
    drive_req(0, 1'b0, '0, '0);
    settle();
    check("fw_wen", rf_wen, 1);
    check("fw_wdata", rf_wdata, 32'h1234);
    check("fw_hit2", fwd_hit2, FWD ? 1 : 0);
    check("fw_data2", fwd_data2, FWD ? 32'h1234 : 32'h0);
    check("fw_busy2", chk_busy2, FWD ? 0 : 1);
    tick();
    check("fw_hit2_after", fwd_hit2, 0);
    check("fw_busy2_after", chk_busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
